stream_req_arbiter: RTL and testbench
=====================================

Name: stream_req_arbiter

Overview:
- Shares the single global-buffer streaming engine among NUM_PE PE controllers.
- Each PE controller raises level-held filter and/or input stream requests. This block picks one winner, round-robin, and issues one command to the streamer.
- Filter requests with identical (k, layer) are merged into one multicast command.
- On streamer completion, it pulses the per-PE finish signals: filter-finish and input-finish respectively.

Parameters:
NUM_PE, 4, number of PE controllers served
MAX_K, 16, maximum output-channel groups; K_W = $clog2(MAX_K)
NUM_LAYER, 4, number of conv layers; L_W = $clog2(NUM_LAYER)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
req_filter_valid  in  NUM_PE  per-PE filter stream request (level, held until finish)
req_filter_k  in  NUM_PE x K_W  per-PE requested filter group k
req_layer  in  NUM_PE x L_W  per-PE conv layer number
req_input_valid  in  NUM_PE  per-PE input-activation stream request (level)
cmd_valid  out  1  command valid to streamer
cmd_ready  in  1  streamer accepts command
cmd_is_input  out  1  1 = input stream, 0 = filter stream
cmd_k  out  K_W  filter group of command (0 for input)
cmd_layer  out  L_W  layer of command
cmd_dest_mask  out  NUM_PE  one-hot (input) or multicast (filter) destination PEs
stream_done  in  1  one-cycle pulse, streamer finished current command
filter_finish  out  NUM_PE  one-cycle finish pulse per PE
input_finish  out  NUM_PE  one-cycle finish pulse per PE
busy  out  1  high in any state other than IDLE

Behaviour:
- All outputs are registered.
- Reset (rst low, asynchronous) forces the following immediately, including mid-transfer:
  - state = IDLE, rr_ptr = 0, blank_mask = 0;
  - cmd_valid = 0, cmd_* = 0, cmd_dest_mask = 0;
  - filter_finish = 0, input_finish = 0, busy = 0.
- The streamer sees no further command after reset. A stream_done arriving after reset is ignored.
- Effective request:
  - eff_in = req_input_valid & ~blank_mask
  - eff_f = req_filter_valid & ~blank_mask
- States: IDLE, ISSUE, WAIT_DONE, RESP.
- IDLE:
  - If eff_in != 0, pick the winner from eff_in by round-robin starting at rr_ptr. Input has priority over filter.
  - Else if eff_f != 0, pick the winner from eff_f the same way.
  - On a pick: register cmd_is_input, cmd_k, cmd_layer and cmd_dest_mask; go to ISSUE. cmd_valid is 1 on the next cycle, so there is 1 cycle of request-to-cmd_valid latency.
  - Filter multicast: dest_mask = the winner bit plus every PE j with eff_f[j], req_filter_k[j] == winner k, and req_layer[j] == winner layer.
  - Input dest_mask is the winner only.
  - rr_ptr <= (winner + 1) mod NUM_PE.
  - blank_mask clears after one IDLE cycle.
- ISSUE:
  - cmd_valid = 1; cmd fields are held stable until the cycle where cmd_valid & cmd_ready.
  - Then go to WAIT_DONE with cmd_valid = 0 next cycle.
  - A stream_done seen in ISSUE is a protocol error and is ignored.
- WAIT_DONE: on stream_done, go to RESP.
- RESP (exactly 1 cycle):
  - filter_finish = cmd_dest_mask if !cmd_is_input, else input_finish = cmd_dest_mask.
  - blank_mask <= cmd_dest_mask; go to IDLE.
  - blank_mask hides the served PEs' stale requests for the following IDLE cycle, because a PE deasserts its request one cycle after seeing finish.
- Requests changing while not in IDLE are ignored; no queueing. Only one command is ever outstanding.
- Minimum turnaround per command is 4 cycles (IDLE → ISSUE with ready=1 → WAIT_DONE with done → RESP).
- Wrap-around: rr_ptr wraps modulo NUM_PE.
- Ties: search order is rr_ptr, rr_ptr+1, …; the first hit wins.

Decomposition:
- Shared package:
  - arb_state_e enum (IDLE, ISSUE, WAIT_DONE, RESP);
  - stream_cmd_t struct (is_input, k, layer, dest_mask);
  - K_W and L_W derived from the existing `max_num_K and `num_of_Conv_Layer macros.
- Sub-module rr_pick (combinational): inputs req vector and ptr; outputs one-hot grant, grant index and any. It is instantiated twice (input and filter).

Test Plan:
- Reset, then req_input_valid = 4'b0010.
  - cmd_valid rises 1 cycle later: cmd_is_input = 1, dest_mask = 0010, rr_ptr → 2.
  - cmd_ready = 1, then stream_done 5 cycles later → input_finish = 0010 for exactly 1 cycle.
- PE0 and PE2 request filter k = 3, layer = 1; PE1 requests k = 5.
  - First command: k = 3, dest_mask = 0101.
  - After RESP and a 1-cycle blank, second command: k = 5, dest_mask = 0010.
- Input and filter requests raised together on PE3 → input command first; filter command next, with dest = 1000, after RESP → IDLE.
- All 4 PEs request input continuously, each dropping it 1 cycle after its finish → grants in order 0, 1, 2, 3; PE3's grant sets rr_ptr = 0 (wrap).
- Hold cmd_ready = 0 for 10 cycles → cmd_valid and all cmd fields stay stable. A stream_done pulsed during ISSUE causes no finish pulse.
- Drive rst low during WAIT_DONE → cmd_valid, busy and the finish vectors are 0 immediately (asynchronously). A later stream_done produces no finish pulse, and a subsequent request is granted from rr_ptr = 0.

Source files
------------

// File: rtl/stream_req_arbiter_pkg.sv
// Shared types and widths for the global-buffer stream request arbiter.
// Widths follow the existing channel-group and conv-layer macros.
`ifndef max_num_K
`define max_num_K 16
`endif
`ifndef num_of_Conv_Layer
`define num_of_Conv_Layer 4
`endif

package stream_req_arbiter_pkg;

    localparam int PE_N = 4;
    localparam int K_W  = $clog2(`max_num_K);
    localparam int L_W  = $clog2(`num_of_Conv_Layer);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        RESP
    } arb_state_e;

    typedef struct packed {
        logic            is_input;
        logic [K_W-1:0]  k;
        logic [L_W-1:0]  layer;
        logic [PE_N-1:0] dest_mask;
    } stream_cmd_t;

endpackage

// File: rtl/stream_req_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping.
module rr_pick
    import stream_req_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    int            j;
    logic [IW-1:0] jj;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        jj    = '0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) begin
                j = j - N;
            end
            jj = IW'(j);
            if (!any && req[jj]) begin
                any       = 1'b1;
                grant[jj] = 1'b1;
                idx       = jj;
            end
        end
    end

endmodule

// File: rtl/stream_req_arbiter.sv
// Shares one global-buffer streamer among PE controllers, round-robin,
// input before filter, merging identical filter requests into a multicast.
module stream_req_arbiter
    import stream_req_arbiter_pkg::*;
#(
    parameter int NUM_PE    = PE_N,
    parameter int MAX_K     = `max_num_K,
    parameter int NUM_LAYER = `num_of_Conv_Layer,
    localparam int KW = $clog2(MAX_K),
    localparam int LW = $clog2(NUM_LAYER),
    localparam int IW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PE-1:0]    req_filter_valid,
    input  logic [NUM_PE*KW-1:0] req_filter_k,
    input  logic [NUM_PE*LW-1:0] req_layer,
    input  logic [NUM_PE-1:0]    req_input_valid,
    output logic                 cmd_valid,
    input  logic                 cmd_ready,
    output logic                 cmd_is_input,
    output logic [KW-1:0]        cmd_k,
    output logic [LW-1:0]        cmd_layer,
    output logic [NUM_PE-1:0]    cmd_dest_mask,
    input  logic                 stream_done,
    output logic [NUM_PE-1:0]    filter_finish,
    output logic [NUM_PE-1:0]    input_finish,
    output logic                 busy
);

    arb_state_e        state;
    stream_cmd_t       cmd_q;
    logic [IW-1:0]     rr_ptr;
    logic [NUM_PE-1:0] blank_mask;

    logic [NUM_PE-1:0] eff_in, eff_f;
    logic [NUM_PE-1:0] in_grant, f_grant, f_mask;
    logic [IW-1:0]     in_idx, f_idx;
    logic              in_any, f_any;
    logic [KW-1:0]     f_k;
    logic [LW-1:0]     f_layer, in_layer;

    assign eff_in = req_input_valid & ~blank_mask;
    assign eff_f  = req_filter_valid & ~blank_mask;

    rr_pick #(.N(NUM_PE), .IW(IW)) u_pick_in (
        .req   (eff_in),
        .ptr   (rr_ptr),
        .grant (in_grant),
        .idx   (in_idx),
        .any   (in_any)
    );

    rr_pick #(.N(NUM_PE), .IW(IW)) u_pick_f (
        .req   (eff_f),
        .ptr   (rr_ptr),
        .grant (f_grant),
        .idx   (f_idx),
        .any   (f_any)
    );

    assign in_layer = req_layer[in_idx*LW +: LW];
    assign f_k      = req_filter_k[f_idx*KW +: KW];
    assign f_layer  = req_layer[f_idx*LW +: LW];

    // Every other PE waiting on the same (k, layer) rides the same stream.
    always_comb begin
        f_mask = f_grant;
        for (int p = 0; p < NUM_PE; p++) begin
            if (eff_f[p]
                && req_filter_k[p*KW +: KW] == f_k
                && req_layer[p*LW +: LW] == f_layer) begin
                f_mask[p] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            blank_mask    <= '0;
            cmd_q         <= '0;
            cmd_valid     <= 1'b0;
            filter_finish <= '0;
            input_finish  <= '0;
            busy          <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    blank_mask <= '0;
                    if (in_any) begin
                        cmd_q.is_input  <= 1'b1;
                        cmd_q.k         <= '0;
                        cmd_q.layer     <= in_layer;
                        cmd_q.dest_mask <= in_grant;
                        rr_ptr    <= (int'(in_idx) == NUM_PE - 1) ? '0 : in_idx + 1'b1;
                        cmd_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end else if (f_any) begin
                        cmd_q.is_input  <= 1'b0;
                        cmd_q.k         <= f_k;
                        cmd_q.layer     <= f_layer;
                        cmd_q.dest_mask <= f_mask;
                        rr_ptr    <= (int'(f_idx) == NUM_PE - 1) ? '0 : f_idx + 1'b1;
                        cmd_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        state     <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (stream_done) begin
                        if (cmd_q.is_input) begin
                            input_finish <= cmd_q.dest_mask;
                        end else begin
                            filter_finish <= cmd_q.dest_mask;
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    // Served PEs still hold their request for one more cycle.
                    blank_mask    <= cmd_q.dest_mask;
                    filter_finish <= '0;
                    input_finish  <= '0;
                    busy          <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign cmd_is_input  = cmd_q.is_input;
    assign cmd_k         = cmd_q.k;
    assign cmd_layer     = cmd_q.layer;
    assign cmd_dest_mask = cmd_q.dest_mask;

endmodule

// File: tb/tb_stream_req_arbiter.sv
// Directed bench for stream_req_arbiter with a command/finish scoreboard.
module tb_stream_req_arbiter;
    import stream_req_arbiter_pkg::*;

    localparam int NPE = 4;
    localparam int KW  = 4;
    localparam int LW  = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [NPE-1:0]   req_filter_valid;
    logic [NPE*KW-1:0] req_filter_k;
    logic [NPE*LW-1:0] req_layer;
    logic [NPE-1:0]   req_input_valid;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_is_input;
    logic [KW-1:0]    cmd_k;
    logic [LW-1:0]    cmd_layer;
    logic [NPE-1:0]   cmd_dest_mask;
    logic             stream_done;
    logic [NPE-1:0]   filter_finish;
    logic [NPE-1:0]   input_finish;
    logic             busy;

    always #5 clk = ~clk;

    stream_req_arbiter dut (
        .clk              (clk),
        .rst              (rst),
        .req_filter_valid (req_filter_valid),
        .req_filter_k     (req_filter_k),
        .req_layer        (req_layer),
        .req_input_valid  (req_input_valid),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_is_input     (cmd_is_input),
        .cmd_k            (cmd_k),
        .cmd_layer        (cmd_layer),
        .cmd_dest_mask    (cmd_dest_mask),
        .stream_done      (stream_done),
        .filter_finish    (filter_finish),
        .input_finish     (input_finish),
        .busy             (busy)
    );

    int n_total = 0;
    int n_pass  = 0;

    stream_cmd_t       exp_cmd_q[$];
    logic [NPE:0]      exp_fin_q[$];
    stream_cmd_t       obs_cmd;
    stream_cmd_t       hold_exp;

    assign obs_cmd = {cmd_is_input, cmd_k, cmd_layer, cmd_dest_mask};

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    function automatic stream_cmd_t mk(input logic is_in, input logic [3:0] k,
                                       input logic [1:0] l,
                                       input logic [3:0] m);
        stream_cmd_t c;
        c.is_input  = is_in;
        c.k         = k;
        c.layer     = l;
        c.dest_mask = m;
        return c;
    endfunction

    task automatic set_pe(input int i, input logic [3:0] k, input logic [1:0] l);
        req_filter_k[i*KW +: KW] = k;
        req_layer[i*LW +: LW]    = l;
    endtask

    task automatic push(input stream_cmd_t c);
        exp_cmd_q.push_back(c);
        exp_fin_q.push_back({c.is_input, c.dest_mask});
    endtask

    task automatic wait_cmd(input string tag);
        int n = 0;
        @(negedge clk);
        while (!cmd_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, " valid"}, 32'(cmd_valid), 32'd1);
        if (cmd_valid && exp_cmd_q.size() > 0) begin
            check({tag, " cmd"}, 32'(obs_cmd), 32'(exp_cmd_q.pop_front()));
            check({tag, " busy"}, 32'(busy), 32'd1);
        end
    endtask

    task automatic accept(input string tag);
        cmd_ready = 1'b1;
        @(posedge clk);
        #1 cmd_ready = 1'b0;
        check({tag, " valid drop"}, 32'(cmd_valid), 32'd0);
    endtask

    task automatic done_after(input int d);
        repeat (d) @(posedge clk);
        #1 stream_done = 1'b1;
        @(posedge clk);
        #1 stream_done = 1'b0;
    endtask

    task automatic wait_fin(input string tag);
        int n = 0;
        logic [NPE:0] e;
        @(negedge clk);
        while ((filter_finish | input_finish) == '0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, " fin seen"}, 32'((filter_finish | input_finish) != '0), 32'd1);
        e = exp_fin_q.pop_front();
        check({tag, " input_finish"}, 32'(input_finish), e[NPE] ? 32'(e[NPE-1:0]) : 32'd0);
        check({tag, " filter_finish"}, 32'(filter_finish), e[NPE] ? 32'd0 : 32'(e[NPE-1:0]));
        @(negedge clk);
        check({tag, " fin width"}, 32'(filter_finish | input_finish), 32'd0);
        check({tag, " busy idle"}, 32'(busy), 32'd0);
    endtask

    task automatic serve(input string tag, input int d);
        wait_cmd(tag);
        accept(tag);
        done_after(d);
        wait_fin(tag);
    endtask

    initial begin
        rst = 1'b1;
        req_filter_valid = '0;
        req_filter_k = '0;
        req_layer = '0;
        req_input_valid = '0;
        cmd_ready = 1'b0;
        stream_done = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("rst cmd_valid", 32'(cmd_valid), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst cmd", 32'(obs_cmd), 32'd0);
        check("rst finish", 32'(filter_finish | input_finish), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        set_pe(0, 4'd3, 2'd1);
        set_pe(1, 4'd5, 2'd1);
        set_pe(2, 4'd3, 2'd1);
        set_pe(3, 4'd2, 2'd3);

        // Single input request, one-cycle latency.
        @(posedge clk);
        #1 req_input_valid = 4'b0010;
        push(mk(1'b1, 4'd0, 2'd1, 4'b0010));
        @(negedge clk);
        check("lat before edge", 32'(cmd_valid), 32'd0);
        @(negedge clk);
        check("lat after edge", 32'(cmd_valid), 32'd1);
        serve("in1", 5);
        req_input_valid = '0;

        // Filter multicast then the leftover group.
        req_filter_valid = 4'b0111;
        push(mk(1'b0, 4'd3, 2'd1, 4'b0101));
        serve("f mc", 2);
        req_filter_valid = 4'b0010;
        push(mk(1'b0, 4'd5, 2'd1, 4'b0010));
        serve("f k5", 1);
        req_filter_valid = '0;

        // Input beats filter on the same PE.
        req_input_valid  = 4'b1000;
        req_filter_valid = 4'b1000;
        push(mk(1'b1, 4'd0, 2'd3, 4'b1000));
        serve("pe3 in", 1);
        req_input_valid = '0;
        push(mk(1'b0, 4'd2, 2'd3, 4'b1000));
        serve("pe3 f", 1);
        req_filter_valid = '0;

        // All PEs on input: rotation and wrap.
        req_input_valid = 4'b1111;
        push(mk(1'b1, 4'd0, 2'd1, 4'b0001));
        push(mk(1'b1, 4'd0, 2'd1, 4'b0010));
        push(mk(1'b1, 4'd0, 2'd1, 4'b0100));
        push(mk(1'b1, 4'd0, 2'd3, 4'b1000));
        for (int i = 0; i < NPE; i++) begin
            serve($sformatf("rr%0d", i), 1);
            req_input_valid[i] = 1'b0;
        end

        // Back-pressure with a stray done during ISSUE.
        set_pe(1, 4'd7, 2'd2);
        req_filter_valid = 4'b0010;
        hold_exp = mk(1'b0, 4'd7, 2'd2, 4'b0010);
        push(hold_exp);
        wait_cmd("hold");
        for (int i = 0; i < 10; i++) begin
            stream_done = (i == 3);
            @(negedge clk);
            check($sformatf("hold%0d valid", i), 32'(cmd_valid), 32'd1);
            check($sformatf("hold%0d cmd", i), 32'(obs_cmd), 32'(hold_exp));
            check($sformatf("hold%0d fin", i), 32'(filter_finish | input_finish), 32'd0);
        end
        stream_done = 1'b0;
        accept("hold");
        done_after(1);
        wait_fin("hold");
        req_filter_valid = '0;

        // Asynchronous reset in WAIT_DONE.
        req_input_valid = 4'b0010;
        push(mk(1'b1, 4'd0, 2'd2, 4'b0010));
        wait_cmd("rst mid");
        accept("rst mid");
        void'(exp_fin_q.pop_back());
        @(posedge clk);
        #3 rst = 1'b0;
        req_input_valid = '0;
        #1;
        check("arst busy", 32'(busy), 32'd0);
        check("arst valid", 32'(cmd_valid), 32'd0);
        check("arst mask", 32'(cmd_dest_mask), 32'd0);
        check("arst fin", 32'(filter_finish | input_finish), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        done_after(1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("post rst fin%0d", i), 32'(filter_finish | input_finish), 32'd0);
            check($sformatf("post rst busy%0d", i), 32'(busy), 32'd0);
        end
        req_input_valid = 4'b1001;
        push(mk(1'b1, 4'd0, 2'd1, 4'b0001));
        serve("ptr0", 1);
        req_input_valid = '0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
